alarm_ctrl: RTL and testbench

//   Alarm stage downstream of the sec/min/hr time-of-day counter. Samples the live time,

---
 rtl/alarm_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_ctrl
//   Alarm stage that sits after the sec/min/hr time-of-day counter. It watches
//   the live time for second boundaries, compares the time against a stored
//   alarm time on each minute boundary and drives the buzzer/LED request
//   through an IDLE / RINGING (/ SNOOZE) state machine.
//
//   Optional feature macro: ALARM_SNOOZE_EN
//     defined     : snooze input honoured, SNOOZE state and snooze target
//                   registers present, snoozing reflects SNOOZE.
//     not defined : snooze input ignored, snoozing tied low, RINGING exits
//                   only on stop, alarm_on deassertion or ring timeout.
//
// Parameters
//   RING_SECS   seconds of ringing before auto-stop          (1..63)
//   SNOOZE_MIN  snooze delay in minutes                      (1..59)
//   MAX_SNOOZE  snoozes per alarm event before snooze = stop (1..7)
//
// Ports
//   clk       in   system clock, posedge
//   rst       in   asynchronous active-high reset
//   sec       in   live seconds 0..59
//   min       in   live minutes 0..59
//   hr        in   live hours 0..23
//   alarm_on  in   level, alarm enabled
//   set_en    in   pulse, load set_hr/set_min as alarm time
//   set_hr    in   alarm hour to load
//   set_min   in   alarm minute to load
//   stop      in   pulse, silence and go idle
//   snooze    in   pulse, snooze request
//   ring      out  registered, high while RINGING
//   snoozing  out  registered, high while SNOOZE
//   alm_hr    out  stored alarm hour
//   alm_min   out  stored alarm minute
//   set_err   out  registered 1-cycle pulse for a rejected set_en
// ---------------------------------------------------------------------------
module alarm_ctrl #(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [5:0] hr,
    input  logic       alarm_on,
    input  logic       set_en,
    input  logic [5:0] set_hr,
    input  logic [5:0] set_min,
    input  logic       stop,
    input  logic       snooze,
    output logic       ring,
    output logic       snoozing,
    output logic [5:0] alm_hr,
    output logic [5:0] alm_min,
    output logic       set_err
);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1
    } state_t;
`endif

    // ring_cnt counts ticks since entering RINGING; the tick that would make
    // it reach RING_SECS is the timeout tick, so it never exceeds RING_LAST.
    localparam logic [5:0] RING_LAST = 6'(RING_SECS - 1);

    state_t     state_reg;
    state_t     state_next;
    logic [5:0] sec_q_reg;
    logic [5:0] ring_cnt_reg;
    logic [5:0] ring_cnt_next;
    logic [5:0] alm_hr_reg;
    logic [5:0] alm_min_reg;
    logic       set_err_reg;
    logic       ring_reg;
    logic       snoozing_reg;

    logic tick;
    logic minute_ev;
    logic alarm_match;
    logic set_ok;

    // A second boundary is any change of the live seconds value. sec_q
    // resets to 0, so a counter sitting at 00:00:00 after reset gives no tick.
    assign tick        = (sec != sec_q_reg);
    assign minute_ev   = tick && (sec == 6'd0);
    assign alarm_match = minute_ev && (hr == alm_hr_reg) && (min == alm_min_reg);
    assign set_ok      = (set_hr <= 6'd23) && (set_min <= 6'd59);

`ifdef ALARM_SNOOZE_EN
    localparam logic [2:0] SNZ_MAX = 3'(MAX_SNOOZE);

    logic [2:0] snz_cnt_reg;
    logic [2:0] snz_cnt_next;
    logic [5:0] snz_hr_reg;
    logic [5:0] snz_hr_next;
    logic [5:0] snz_min_reg;
    logic [5:0] snz_min_next;
    logic [6:0] min_sum;
    logic       min_wrap;
    logic [5:0] snz_min_calc;
    logic [5:0] snz_hr_calc;
    logic       snz_match;

    // Snooze target = now + SNOOZE_MIN, minute mod 60 with carry into the
    // hour, hour wrapping 23 -> 0. 7-bit sum so min + SNOOZE_MIN cannot overflow.
    assign min_sum      = {1'b0, min} + 7'(SNOOZE_MIN);
    assign min_wrap     = (min_sum >= 7'd60);
    assign snz_min_calc = min_wrap ? 6'(min_sum - 7'd60) : min_sum[5:0];
    assign snz_hr_calc  = !min_wrap      ? hr :
                          (hr >= 6'd23)  ? 6'd0 : hr + 6'd1;
    assign snz_match    = minute_ev && (hr == snz_hr_reg) && (min == snz_min_reg);
`else
    logic unused_snooze;
    assign unused_snooze = snooze;
`endif

    // Next-state logic. Priority inside a state: !alarm_on > stop > snooze
    // > timeout > match.
    always_comb begin
        state_next    = state_reg;
        ring_cnt_next = ring_cnt_reg;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_next  = snz_cnt_reg;
        snz_hr_next   = snz_hr_reg;
        snz_min_next  = snz_min_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (alarm_on && alarm_match) begin
                    state_next    = RINGING;
                    ring_cnt_next = 6'd0;
`ifdef ALARM_SNOOZE_EN
                    snz_cnt_next  = 3'd0;
`endif
                end
            end
            RINGING: begin
                if (!alarm_on || stop) begin
                    state_next = IDLE;
                end
`ifdef ALARM_SNOOZE_EN
                else if (snooze) begin
                    if (snz_cnt_reg < SNZ_MAX) begin
                        state_next   = SNOOZE;
                        snz_cnt_next = snz_cnt_reg + 3'd1;
                        snz_hr_next  = snz_hr_calc;
                        snz_min_next = snz_min_calc;
                    end else begin
                        // Snooze budget used up: behaves as stop.
                        state_next = IDLE;
                    end
                end
`endif
                else if (tick) begin
                    if (ring_cnt_reg == RING_LAST) begin
                        state_next = IDLE;
                    end else begin
                        ring_cnt_next = ring_cnt_reg + 6'd1;
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (!alarm_on || stop) begin
                    state_next = IDLE;
                end else if (snz_match) begin
                    state_next    = RINGING;
                    ring_cnt_next = 6'd0;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            sec_q_reg    <= 6'd0;
            ring_cnt_reg <= 6'd0;
            ring_reg     <= 1'b0;
            snoozing_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sec_q_reg    <= sec;
            ring_cnt_reg <= ring_cnt_next;
            ring_reg     <= (state_next == RINGING);
`ifdef ALARM_SNOOZE_EN
            snoozing_reg <= (state_next == SNOOZE);
`else
            snoozing_reg <= 1'b0;
`endif
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snz_cnt_reg <= 3'd0;
            snz_hr_reg  <= 6'd0;
            snz_min_reg <= 6'd0;
        end else begin
            snz_cnt_reg <= snz_cnt_next;
            snz_hr_reg  <= snz_hr_next;
            snz_min_reg <= snz_min_next;
        end
    end
`endif

    // Alarm time register. The compare above uses the current register
    // value, so a set_en landing on a match cycle still matches the old time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alm_hr_reg  <= 6'd0;
            alm_min_reg <= 6'd0;
            set_err_reg <= 1'b0;
        end else begin
            set_err_reg <= set_en && !set_ok;
            if (set_en && set_ok) begin
                alm_hr_reg  <= set_hr;
                alm_min_reg <= set_min;
            end
        end
    end

    assign ring     = ring_reg;
    assign snoozing = snoozing_reg;
    assign alm_hr   = alm_hr_reg;
    assign alm_min  = alm_min_reg;
    assign set_err  = set_err_reg;

endmodule

// File: tb/tb_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alarm_ctrl
//   Self-checking bench for alarm_ctrl (default parameters). A vector table
//   covers alarm setting, match/stop, alarm_on gating and set-during-match;
//   hand sequences cover ring timeout, snooze behaviour and async reset.
// ---------------------------------------------------------------------------
module tb_alarm_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] sec;
    logic [5:0] min;
    logic [5:0] hr;
    logic       alarm_on;
    logic       set_en;
    logic [5:0] set_hr;
    logic [5:0] set_min;
    logic       stop;
    logic       snooze;
    logic       ring;
    logic       snoozing;
    logic [5:0] alm_hr;
    logic [5:0] alm_min;
    logic       set_err;

    int checks = 0;
    int errors = 0;

    alarm_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .sec      (sec),
        .min      (min),
        .hr       (hr),
        .alarm_on (alarm_on),
        .set_en   (set_en),
        .set_hr   (set_hr),
        .set_min  (set_min),
        .stop     (stop),
        .snooze   (snooze),
        .ring     (ring),
        .snoozing (snoozing),
        .alm_hr   (alm_hr),
        .alm_min  (alm_min),
        .set_err  (set_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] hr;
        logic [5:0] mn;
        logic [5:0] sc;
        logic       on;
        logic       se;
        logic [5:0] shr;
        logic [5:0] smn;
        logic       stp;
        logic       e_ring;
        logic [5:0] e_ahr;
        logic [5:0] e_amin;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int h, int m, int s, int on, int se, int shr, int smn,
                                int stp, int e_ring, int e_ahr, int e_amin, int e_err);
        vec_t v;
        v.hr = 6'(h);      v.mn = 6'(m);       v.sc = 6'(s);
        v.on = 1'(on);     v.se = 1'(se);      v.shr = 6'(shr);  v.smn = 6'(smn);
        v.stp = 1'(stp);   v.e_ring = 1'(e_ring);
        v.e_ahr = 6'(e_ahr); v.e_amin = 6'(e_amin); v.e_err = 1'(e_err);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hr = 6'(h); min = 6'(m); sec = 6'(s);
    endtask

    // Drive a time for one cycle and check ring/snoozing afterwards.
    task automatic step(input string nm, input int h, input int m, input int s,
                        input int e_ring, input int e_snz);
        set_time(h, m, s);
        cyc();
        $display("step %s %02d:%02d:%02d ring=%0d snoozing=%0d", nm, h, m, s, ring, snoozing);
        chk({nm, ".ring"}, int'(ring), e_ring);
        chk({nm, ".snoozing"}, int'(snoozing), e_snz);
    endtask

    task automatic set_alarm(input int h, input int m);
        set_en = 1'b1; set_hr = 6'(h); set_min = 6'(m);
        cyc();
        set_en = 1'b0;
        chk("set_alarm.hr", int'(alm_hr), h);
        chk("set_alarm.min", int'(alm_min), m);
    endtask

    initial begin
        rst = 1'b1; sec = '0; min = '0; hr = '0; alarm_on = 1'b0;
        set_en = 1'b0; set_hr = '0; set_min = '0; stop = 1'b0; snooze = 1'b0;

        // hr, min, sec, on, set_en, set_hr, set_min, stop, exp ring, exp alm hr/min, exp set_err
        vecs.push_back(mk( 0,  0,  0, 0, 1,  6, 30, 0, 0,  6, 30, 0)); // valid set
        vecs.push_back(mk( 0,  0,  0, 0, 1, 24, 10, 0, 0,  6, 30, 1)); // hr out of range
        vecs.push_back(mk( 0,  0,  0, 0, 0,  0,  0, 0, 0,  6, 30, 0)); // err is a pulse
        vecs.push_back(mk( 0,  0,  0, 0, 1,  5, 60, 0, 0,  6, 30, 1)); // min out of range
        vecs.push_back(mk( 0,  0,  0, 0, 1, 23, 59, 0, 0, 23, 59, 0)); // max legal
        vecs.push_back(mk( 0,  0,  0, 0, 1,  6, 30, 0, 0,  6, 30, 0));
        vecs.push_back(mk( 6, 29, 58, 1, 0,  0,  0, 0, 0,  6, 30, 0));
        vecs.push_back(mk( 6, 29, 59, 1, 0,  0,  0, 0, 0,  6, 30, 0));
        vecs.push_back(mk( 6, 30,  0, 1, 0,  0,  0, 0, 1,  6, 30, 0)); // match
        vecs.push_back(mk( 6, 30,  1, 1, 0,  0,  0, 0, 1,  6, 30, 0));
        vecs.push_back(mk( 6, 30,  1, 1, 0,  0,  0, 1, 0,  6, 30, 0)); // stop
        vecs.push_back(mk( 6, 30,  2, 1, 0,  0,  0, 0, 0,  6, 30, 0));
        vecs.push_back(mk( 6, 29, 59, 0, 0,  0,  0, 0, 0,  6, 30, 0));
        vecs.push_back(mk( 6, 30,  0, 0, 0,  0,  0, 0, 0,  6, 30, 0)); // disabled match
        vecs.push_back(mk( 6, 30,  0, 1, 0,  0,  0, 0, 0,  6, 30, 0)); // no tick, no match
        vecs.push_back(mk( 6, 29, 59, 1, 0,  0,  0, 0, 0,  6, 30, 0));
        vecs.push_back(mk( 6, 30,  0, 1, 1,  7,  0, 0, 1,  7,  0, 0)); // set on match: old compare
        vecs.push_back(mk( 6, 30,  1, 1, 0,  0,  0, 1, 0,  7,  0, 0));
        vecs.push_back(mk( 6, 59, 59, 1, 0,  0,  0, 0, 0,  7,  0, 0));
        vecs.push_back(mk( 7,  0,  0, 1, 0,  0,  0, 0, 1,  7,  0, 0));
        vecs.push_back(mk( 7,  0,  0, 0, 0,  0,  0, 0, 0,  7,  0, 0)); // alarm_on drop
        vecs.push_back(mk( 7,  0,  1, 1, 0,  0,  0, 0, 0,  7,  0, 0)); // no re-trigger
        vecs.push_back(mk( 6, 59, 59, 1, 0,  0,  0, 0, 0,  7,  0, 0));
        vecs.push_back(mk( 7,  0,  0, 1, 0,  0,  0, 0, 1,  7,  0, 0));
        vecs.push_back(mk( 7,  0,  0, 1, 1, 30,  0, 0, 1,  7,  0, 1)); // bad set while ringing
        vecs.push_back(mk( 7,  0,  1, 1, 0,  0,  0, 1, 0,  7,  0, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset.ring", int'(ring), 0);
        chk("reset.snoozing", int'(snoozing), 0);
        chk("reset.alm_hr", int'(alm_hr), 0);
        chk("reset.alm_min", int'(alm_min), 0);
        chk("reset.set_err", int'(set_err), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            set_time(int'(vecs[i].hr), int'(vecs[i].mn), int'(vecs[i].sc));
            alarm_on = vecs[i].on;
            set_en   = vecs[i].se;
            set_hr   = vecs[i].shr;
            set_min  = vecs[i].smn;
            stop     = vecs[i].stp;
            cyc();
            $display("vec %0d %02d:%02d:%02d ring=%0d alm=%02d:%02d set_err=%0d",
                     i, vecs[i].hr, vecs[i].mn, vecs[i].sc, ring, alm_hr, alm_min, set_err);
            chk($sformatf("vec%0d.ring", i), int'(ring), int'(vecs[i].e_ring));
            chk($sformatf("vec%0d.snoozing", i), int'(snoozing), 0);
            chk($sformatf("vec%0d.alm_hr", i), int'(alm_hr), int'(vecs[i].e_ahr));
            chk($sformatf("vec%0d.alm_min", i), int'(alm_min), int'(vecs[i].e_amin));
            chk($sformatf("vec%0d.set_err", i), int'(set_err), int'(vecs[i].e_err));
        end
        set_en = 1'b0; stop = 1'b0; alarm_on = 1'b1;

        // Auto-timeout: 60 ticks after the match tick the ring drops.
        step("to_pre", 6, 59, 59, 0, 0);
        step("to_match", 7, 0, 0, 1, 0);
        for (int k = 1; k <= 62; k++) begin
            step($sformatf("to_tick%0d", k), 7, (k >= 60) ? 1 : 0, k % 60,
                 (k < 60) ? 1 : 0, 0);
        end

`ifdef ALARM_SNOOZE_EN
        // Snooze across midnight: 23:57 + 5 min -> 00:02.
        set_time(23, 56, 58);
        set_alarm(23, 57);
        step("sz_pre", 23, 56, 59, 0, 0);
        step("sz_ring1", 23, 57, 0, 1, 0);
        snooze = 1'b1; step("sz_snz1", 23, 57, 0, 0, 1); snooze = 1'b0;
        step("sz_wait1", 0, 1, 59, 0, 1);
        step("sz_ring2", 0, 2, 0, 1, 0);
        snooze = 1'b1; step("sz_snz2", 0, 2, 0, 0, 1); snooze = 1'b0;
        step("sz_wait2", 0, 6, 59, 0, 1);
        step("sz_ring3", 0, 7, 0, 1, 0);
        snooze = 1'b1; step("sz_snz3", 0, 7, 0, 0, 1); snooze = 1'b0;
        step("sz_wait3", 0, 11, 59, 0, 1);
        step("sz_ring4", 0, 12, 0, 1, 0);
        snooze = 1'b1; step("sz_snz4_stop", 0, 12, 0, 0, 0); snooze = 1'b0;
        step("sz_after4", 0, 12, 1, 0, 0);
        // stop and snooze together -> idle
        set_alarm(0, 13);
        step("ss_pre", 0, 12, 59, 0, 0);
        step("ss_ring", 0, 13, 0, 1, 0);
        stop = 1'b1; snooze = 1'b1;
        step("ss_both", 0, 13, 0, 0, 0);
        stop = 1'b0; snooze = 1'b0;
        // stop while snoozing -> idle
        step("sp_pre", 0, 12, 59, 0, 0);
        step("sp_ring", 0, 13, 0, 1, 0);
        snooze = 1'b1; step("sp_snz", 0, 13, 0, 0, 1); snooze = 1'b0;
        stop = 1'b1; step("sp_stop", 0, 13, 1, 0, 0); stop = 1'b0;
        step("sp_target", 0, 18, 0, 0, 0);
`else
        // Without the snooze feature a snooze pulse leaves the ring alone.
        step("ns_pre", 6, 59, 59, 0, 0);
        step("ns_ring", 7, 0, 0, 1, 0);
        snooze = 1'b1; step("ns_snooze", 7, 0, 0, 1, 0); snooze = 1'b0;
        stop = 1'b1; step("ns_stop", 7, 0, 1, 0, 0); stop = 1'b0;
`endif

        // Asynchronous reset in the middle of a ring.
        set_time(7, 59, 58);
        set_alarm(8, 0);
        step("rs_pre", 7, 59, 59, 0, 0);
        step("rs_ring", 8, 0, 0, 1, 0);
        #2 rst = 1'b1;
        #1;
        $display("async reset ring=%0d alm=%02d:%02d", ring, alm_hr, alm_min);
        chk("rs_async.ring", int'(ring), 0);
        chk("rs_async.snoozing", int'(snoozing), 0);
        chk("rs_async.alm_hr", int'(alm_hr), 0);
        chk("rs_async.alm_min", int'(alm_min), 0);
        cyc();
        rst = 1'b0;
        step("rs_after", 8, 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
